fetch_unit: RTL

- Instruction-fetch front end sitting directly upstream of the single-cycle datapath.
- Owns the fetch PC and issues word requests to a variable-latency instruction memory.
- Buffers returned instructions with their PCs in a small in-order queue and hands them to decode over a valid/ready handshake.
- Branch redirects from the execute stage flush the queue and drop stale in-flight responses.

---
 rtl/fetch_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues word requests to a variable-latency
// instruction memory and queues returned {pc, instr} pairs in order for decode.
module fetch_unit #(
    parameter int unsigned     XLEN            = 64,
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr
);

    localparam int unsigned QAW = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned IW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [IW-1:0]   infl_q, infl_d;
    logic [IW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count_q, count_d;
    logic [QAW-1:0]  head_q, head_d;
    logic [QAW-1:0]  tail_q, tail_d;
    logic [PAW-1:0]  pf_rd_q, pf_rd_d;
    logic [PAW-1:0]  pf_wr_q, pf_wr_d;

    logic [XLEN-1:0] q_pc_q    [DEPTH];
    logic [31:0]     q_instr_q [DEPTH];
    // PCs of granted requests, consumed in order as responses return (dropped ones included).
    logic [XLEN-1:0] pf_pc_q   [MAX_OUTSTANDING];

    logic [31:0] occupancy;
    logic        grant;
    logic        push;
    logic        pop;

    function automatic logic [PAW-1:0] pf_inc(input logic [PAW-1:0] p);
        return (p == PAW'(MAX_OUTSTANDING - 1)) ? '0 : p + PAW'(1);
    endfunction

    always_comb begin
        occupancy = 32'(count_q) + 32'(infl_q);
        imem_req  = reset && !redirect_valid && (32'(infl_q) < MAX_OUTSTANDING)
                    && (occupancy < DEPTH);
        imem_addr = fetch_pc_q;
        grant     = imem_req && imem_gnt;
        out_valid = (count_q != '0);
        out_pc    = out_valid ? q_pc_q[head_q] : '0;
        out_instr = out_valid ? q_instr_q[head_q] : '0;
        push      = imem_rvalid && (drop_q == '0) && !redirect_valid;
        pop       = out_valid && out_ready && !redirect_valid;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        infl_d     = infl_q + IW'(grant) - IW'(imem_rvalid);
        drop_d     = drop_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        head_d     = pop ? head_q + QAW'(1) : head_q;
        tail_d     = push ? tail_q + QAW'(1) : tail_q;
        pf_wr_d    = grant ? pf_inc(pf_wr_q) : pf_wr_q;
        pf_rd_d    = imem_rvalid ? pf_inc(pf_rd_q) : pf_rd_q;

        if (grant) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        if (imem_rvalid && (drop_q != '0)) begin
            drop_d = drop_q - IW'(1);
        end

        // Every response still owed after a redirect belongs to the old stream.
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            drop_d     = infl_d;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            infl_q     <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            pf_rd_q    <= '0;
            pf_wr_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            infl_q     <= infl_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            pf_rd_q    <= pf_rd_d;
            pf_wr_q    <= pf_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            pf_pc_q[pf_wr_q] <= fetch_pc_q;
        end
        if (push) begin
            q_pc_q[tail_q]    <= pf_pc_q[pf_rd_q];
            q_instr_q[tail_q] <= imem_rdata;
        end
    end

endmodule
